rls803_shifter: RTL and testbench

- 8-bit logical barrel shifter with 3-bit shift amount and selectable direction; fills vacated bit positions with zeros.
- Primary result `data_out` is combinational and is valid without any clock edge.
- Active-low clear forces the result to zero.
- A registered copy of the result (`data_out_q`) is captured on `clk` for pipelined consumers in the ALU/datapath.

---
 rtl/rls803_shifter_if.sv | 42 ++++
 rtl/rls803_shifter.sv | 74 +++++++
 tb/tb_rls803_shifter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rls803_shifter_if.sv
// ---------------------------------------------------------------------------
// rls803_shifter_if
// Bundles the operand/result signals of the logical barrel shifter so the
// datapath can hand the whole bus to the shifter as a single port.
//
// Signals:
//   data_in      operand to shift (driven by master)
//   shift_amount number of bit positions 0..WIDTH-1 (driven by master)
//   direction    0 = logical right, 1 = logical left (driven by master)
//   data_out     combinational shift result (driven by slave)
//   data_out_q   registered copy of data_out (driven by slave)
//
// Modports:
//   master  the consumer/driver of operands (ALU, testbench)
//   slave   the shifter itself
// ---------------------------------------------------------------------------
interface rls803_shifter_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shift_amount;
    logic               direction;
    logic [WIDTH-1:0]   data_out;
    logic [WIDTH-1:0]   data_out_q;

    modport master (
        output data_in,
        output shift_amount,
        output direction,
        input  data_out,
        input  data_out_q
    );

    modport slave (
        input  data_in,
        input  shift_amount,
        input  direction,
        output data_out,
        output data_out_q
    );
endinterface

// File: rtl/rls803_shifter.sv
// ---------------------------------------------------------------------------
// rls803_shifter
// Logical barrel shifter (zero fill, no rotate, no sign fill) with a
// combinational result and a registered copy for pipelined consumers.
//
// Ports:
//   clk      system clock; rising edge loads data_out_q
//   clear_n  asynchronous active-low clear; forces data_out and data_out_q
//            to zero while low
//   bus      rls803_shifter_if.slave carrying data_in, shift_amount,
//            direction (inputs) and data_out, data_out_q (outputs)
//
// Structure: a single right shifter built from log2(WIDTH) mux stages
// (shift by 1, 2, 4, ...). Left shifts reuse it by bit-reversing the operand
// going in and the result coming out.
// ---------------------------------------------------------------------------
module rls803_shifter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic                  clk,
    input  logic                  clear_n,
    rls803_shifter_if.slave       bus
);

    logic [WIDTH-1:0] w_stage_in;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_data_q;

    // Mirror bit order: bit i <-> bit WIDTH-1-i.
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // A left shift is a right shift of the mirrored operand, mirrored back.
    always_comb begin
        w_stage_in = bus.direction ? bit_reverse(bus.data_in) : bus.data_in;
    end

    // One mux stage per shift_amount bit; stage k shifts by 2**k.
    always_comb begin
        w_shifted = w_stage_in;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (bus.shift_amount[k]) begin
                w_shifted = w_shifted >> (1 << k);
            end
        end
    end

    // Clear gates the combinational result directly, independent of clk.
    always_comb begin
        w_result = '0;
        if (clear_n) begin
            w_result = bus.direction ? bit_reverse(w_shifted) : w_shifted;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= w_result;
        end
    end

    assign bus.data_out   = w_result;
    assign bus.data_out_q = r_data_q;

endmodule

// File: tb/tb_rls803_shifter.sv
// ---------------------------------------------------------------------------
// tb_rls803_shifter
// Self-checking bench for rls803_shifter: directed cases, clear behaviour
// and randomized operands compared with an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_rls803_shifter;

    logic clk;
    logic clk_en;
    logic clear_n;
    int   tests;
    int   fails;

    rls803_shifter_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

    rls803_shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    // Clock only toggles once enabled so the combinational checks run clockless.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Reference: shifting by n is multiply/divide by 2**n on an 8-bit value.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int sh, input logic dir);
        int v;
        if (dir) v = (int'(d) * (1 << sh)) % 256;
        else     v = int'(d) / (1 << sh);
        return 8'(v);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] sh, input logic dir);
        bus.data_in      = d;
        bus.shift_amount = sh;
        bus.direction    = dir;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic [2:0] sh;
        logic       dir;
        logic [7:0] exp_q;

        tests  = 0;
        fails  = 0;
        clk_en = 1'b0;

        // Clear asserted, no clock: both outputs must read zero.
        clear_n = 1'b0;
        drive(8'b11111111, 3'b000, 1'b0);
        #10;
        check("reset_out", bus.data_out, 8'h00);
        check("reset_q",   bus.data_out_q, 8'h00);

        // Combinational directed cases, still without any clock.
        clear_n = 1'b1;
        drive(8'b10101010, 3'b000, 1'b0); #10;
        check("pass_r0", bus.data_out, 8'b10101010);
        check("q_no_clock", bus.data_out_q, 8'h00);
        drive(8'b10101010, 3'b000, 1'b1); #10;
        check("pass_l0", bus.data_out, 8'b10101010);
        drive(8'b10101010, 3'b010, 1'b0); #10;
        check("r2", bus.data_out, 8'b00101010);
        drive(8'b10101010, 3'b011, 1'b1); #10;
        check("l3", bus.data_out, 8'b01010000);
        drive(8'b10101010, 3'b111, 1'b1); #10;
        check("l7_aa", bus.data_out, 8'b00000000);
        drive(8'b00000001, 3'b111, 1'b1); #10;
        check("l7_01", bus.data_out, 8'b10000000);
        drive(8'b10000000, 3'b111, 1'b0); #10;
        check("r7_80", bus.data_out, 8'b00000001);
        drive(8'b01111111, 3'b111, 1'b0); #10;
        check("r7_7f", bus.data_out, 8'b00000000);

        // Clear forces output to zero at once, release restores it at once.
        drive(8'b11111111, 3'b000, 1'b0);
        clear_n = 1'b0; #1;
        check("clr_comb", bus.data_out, 8'h00);
        clear_n = 1'b1; #1;
        check("release_comb", bus.data_out, 8'hFF);

        // Clocked section.
        clk_en = 1'b1;
        @(negedge clk);
        drive(8'b11000011, 3'b001, 1'b0); #1;
        check("clk_r1_comb", bus.data_out, 8'b01100001);
        @(posedge clk); #1;
        check("clk_r1_q", bus.data_out_q, 8'b01100001);

        // Clear pulse between edges.
        @(negedge clk); #1;
        clear_n = 1'b0; #1;
        check("pulse_q", bus.data_out_q, 8'h00);
        check("pulse_out", bus.data_out, 8'h00);
        @(posedge clk); #1;
        check("pulse_q_held", bus.data_out_q, 8'h00);
        @(negedge clk); #1;
        clear_n = 1'b1; #1;
        check("rel_out", bus.data_out, 8'b01100001);
        check("rel_q_waits", bus.data_out_q, 8'h00);
        @(posedge clk); #1;
        check("rel_q_load", bus.data_out_q, 8'b01100001);

        // Randomized operands; q must hold until the edge, then load.
        exp_q = 8'b01100001;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            d   = 8'($urandom);
            sh  = 3'($urandom_range(0, 7));
            dir = 1'($urandom);
            drive(d, sh, dir); #1;
            check("rnd_comb", bus.data_out, ref_shift(d, int'(sh), dir));
            check("rnd_q_hold", bus.data_out_q, exp_q);
            @(posedge clk); #1;
            exp_q = ref_shift(d, int'(sh), dir);
            check("rnd_q", bus.data_out_q, exp_q);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
